// File: rtl/bru_bht.sv
// Branch resolution unit with direct-mapped BHT/BTB (2-bit counters); optional perf counters via BRU_PERF_EN.
// Latency: prediction and resolve/redirect are combinational; table/counter updates land at the next i_clk edge.
// Backpressure: i_id_stall blocks table and counter updates; o_ifid_nop still follows the misprediction.
module bru_bht #(
  parameter int         CPU_WIDTH = 64,
  parameter int         BHT_DEPTH = 64,
  parameter int         TAG_W     = 8,
  parameter logic [1:0] CNT_INIT  = 2'b10
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [CPU_WIDTH-1:0] i_ifupc,
  output logic                 o_pred_taken,
  output logic [CPU_WIDTH-1:0] o_pred_pc,
  input  logic                 i_id_valid,
  input  logic                 i_id_stall,
  input  logic                 i_jal,
  input  logic                 i_jalr,
  input  logic                 i_brch,
  input  logic [2:0]           i_bfun3,
  input  logic [CPU_WIDTH-1:0] i_rs1,
  input  logic [CPU_WIDTH-1:0] i_rs2,
  input  logic [CPU_WIDTH-1:0] i_imm,
  input  logic [CPU_WIDTH-1:0] i_idupc,
  input  logic                 i_id_pred_taken,
  input  logic [CPU_WIDTH-1:0] i_id_pred_pc,
  input  logic                 i_bht_clr,
  output logic [CPU_WIDTH-1:0] o_next_pc,
  output logic                 o_ifid_nop,
  output logic [31:0]          o_br_cnt,
  output logic [31:0]          o_mis_cnt
);

  localparam int IDX_W = $clog2(BHT_DEPTH);
  localparam logic [CPU_WIDTH-1:0] PC_STEP = CPU_WIDTH'(4);

  typedef struct packed {
    logic                 valid;
    logic [TAG_W-1:0]     tag;
    logic [CPU_WIDTH-1:0] target;
    logic [1:0]           cnt;
    logic                 is_jump;
  } bht_ent_t;

  bht_ent_t tbl [BHT_DEPTH];

  // IF-side lookup
  logic [IDX_W-1:0] pidx;
  logic [TAG_W-1:0] ptag;
  logic             phit;

  assign pidx         = i_ifupc[IDX_W+1:2];
  assign ptag         = i_ifupc[IDX_W+2 +: TAG_W];
  assign phit         = tbl[pidx].valid && (tbl[pidx].tag == ptag);
  assign o_pred_taken = phit && (tbl[pidx].is_jump || tbl[pidx].cnt[1]);
  assign o_pred_pc    = tbl[pidx].target;

  // ID-side condition evaluation; the extra top bit of diff is the unsigned borrow
  logic [CPU_WIDTH:0]   diff;
  logic                 br_eq, br_ltu, br_lt, cond;
  logic                 is_ctrl, taken, mis;
  logic [CPU_WIDTH-1:0] jalr_sum, tgt;

  assign diff     = {1'b0, i_rs1} - {1'b0, i_rs2};
  assign br_eq    = (diff[CPU_WIDTH-1:0] == '0);
  assign br_ltu   = diff[CPU_WIDTH];
  assign br_lt    = (i_rs1[CPU_WIDTH-1] ^ i_rs2[CPU_WIDTH-1]) ? i_rs1[CPU_WIDTH-1] : diff[CPU_WIDTH-1];

  // Decode funct3 into the branch condition; reserved encodings never branch
  always_comb begin
    cond = 1'b0;
    case (i_bfun3)
      3'b000:  cond = br_eq;
      3'b001:  cond = ~br_eq;
      3'b100:  cond = br_lt;
      3'b101:  cond = ~br_lt;
      3'b110:  cond = br_ltu;
      3'b111:  cond = ~br_ltu;
      default: cond = 1'b0;
    endcase
  end

  assign is_ctrl  = i_brch | i_jal | i_jalr;
  assign taken    = (i_brch & cond) | i_jal | i_jalr;
  assign jalr_sum = i_rs1 + i_imm;
  assign tgt      = i_jalr ? {jalr_sum[CPU_WIDTH-1:1], 1'b0} : (i_idupc + i_imm);
  // A prediction on a non-control instruction (alias) falls out as taken=0 vs pred=1
  assign mis      = i_id_valid & ((taken != i_id_pred_taken) | (taken & (tgt != i_id_pred_pc)));

  assign o_ifid_nop = mis;

  // Redirect on mispredict first, then follow the prediction, else fall through
  always_comb begin
    o_next_pc = i_ifupc + PC_STEP;
    if (mis)
      o_next_pc = taken ? tgt : (i_idupc + PC_STEP);
    else if (o_pred_taken)
      o_next_pc = o_pred_pc;
  end

  // Training lookup on the ID PC
  logic [IDX_W-1:0] uidx;
  logic [TAG_W-1:0] utag;
  logic             uhit, upd, alias_inv;

  assign uidx      = i_idupc[IDX_W+1:2];
  assign utag      = i_idupc[IDX_W+2 +: TAG_W];
  assign uhit      = tbl[uidx].valid && (tbl[uidx].tag == utag);
  assign upd       = i_id_valid & ~i_id_stall & is_ctrl;
  assign alias_inv = i_id_valid & ~i_id_stall & ~is_ctrl & i_id_pred_taken & uhit;

  // Table state: clear beats update; hit trains, taken miss allocates, alias drops the entry
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        tbl[i].valid   <= 1'b0;
        tbl[i].tag     <= '0;
        tbl[i].target  <= '0;
        tbl[i].cnt     <= 2'b01;
        tbl[i].is_jump <= 1'b0;
      end
    end else if (i_bht_clr) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        tbl[i].valid <= 1'b0;
      end
    end else if (upd) begin
      if (uhit) begin
        if (taken && tbl[uidx].cnt != 2'b11)
          tbl[uidx].cnt <= tbl[uidx].cnt + 2'b01;
        else if (!taken && tbl[uidx].cnt != 2'b00)
          tbl[uidx].cnt <= tbl[uidx].cnt - 2'b01;
        if (taken)
          tbl[uidx].target <= tgt;
        tbl[uidx].is_jump <= i_jal | i_jalr;
      end else if (taken) begin
        tbl[uidx].valid   <= 1'b1;
        tbl[uidx].tag     <= utag;
        tbl[uidx].target  <= tgt;
        tbl[uidx].cnt     <= CNT_INIT;
        tbl[uidx].is_jump <= i_jal | i_jalr;
      end
    end else if (alias_inv) begin
      tbl[uidx].valid <= 1'b0;
    end
  end

`ifdef BRU_PERF_EN
  logic [31:0] br_cnt_q, mis_cnt_q;

  // Count resolved control transfers and the mispredicted subset
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else if (upd) begin
      br_cnt_q <= br_cnt_q + 32'd1;
      if (mis)
        mis_cnt_q <= mis_cnt_q + 32'd1;
    end
  end

  assign o_br_cnt  = br_cnt_q;
  assign o_mis_cnt = mis_cnt_q;
`else
  assign o_br_cnt  = '0;
  assign o_mis_cnt = '0;
`endif

endmodule

// File: tb/tb_bru_bht.sv
// Directed bench for bru_bht: reset, allocation, saturation, jalr, stall/clear, signed/unsigned compare, alias.
// Inputs change just after the falling edge; outputs are checked 1ns later, well before the rising edge.
// Expected perf counter values follow a local model and collapse to 0 when BRU_PERF_EN is undefined.
module tb_bru_bht;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] ifupc;
  logic        pred_taken;
  logic [63:0] pred_pc;
  logic        id_valid, id_stall, jal, jalr, brch;
  logic [2:0]  bfun3;
  logic [63:0] rs1, rs2, imm, idupc;
  logic        id_pred_taken;
  logic [63:0] id_pred_pc;
  logic        bht_clr;
  logic [63:0] next_pc;
  logic        ifid_nop;
  logic [31:0] br_cnt, mis_cnt;

  int total = 0;
  int bad   = 0;
  int exp_br  = 0;
  int exp_mis = 0;
  logic [31:0] eb, em;

  always #5 clk = ~clk;

  bru_bht dut (
    .i_clk(clk), .i_rst(rst), .i_ifupc(ifupc),
    .o_pred_taken(pred_taken), .o_pred_pc(pred_pc),
    .i_id_valid(id_valid), .i_id_stall(id_stall),
    .i_jal(jal), .i_jalr(jalr), .i_brch(brch), .i_bfun3(bfun3),
    .i_rs1(rs1), .i_rs2(rs2), .i_imm(imm), .i_idupc(idupc),
    .i_id_pred_taken(id_pred_taken), .i_id_pred_pc(id_pred_pc),
    .i_bht_clr(bht_clr), .o_next_pc(next_pc), .o_ifid_nop(ifid_nop),
    .o_br_cnt(br_cnt), .o_mis_cnt(mis_cnt)
  );

  task automatic idle();
    id_valid = 0; id_stall = 0; jal = 0; jalr = 0; brch = 0; bfun3 = 3'b000;
    rs1 = 0; rs2 = 0; imm = 0; idupc = 0; id_pred_taken = 0; id_pred_pc = 0; bht_clr = 0;
  endtask

  task automatic drive_br(input logic [2:0] f3, input logic [63:0] pc, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] im, input logic pt, input logic [63:0] pp);
    idle();
    id_valid = 1; brch = 1; bfun3 = f3; idupc = pc; rs1 = a; rs2 = b; imm = im;
    id_pred_taken = pt; id_pred_pc = pp;
  endtask

  task automatic check_perf(input string tag);
`ifdef BRU_PERF_EN
    eb = exp_br; em = exp_mis;
`else
    eb = 0; em = 0;
`endif
    total++;
    if (br_cnt !== eb) begin $display("FAIL %s br_cnt got=%0d exp=%0d", tag, br_cnt, eb); bad++; end
    total++;
    if (mis_cnt !== em) begin $display("FAIL %s mis_cnt got=%0d exp=%0d", tag, mis_cnt, em); bad++; end
  endtask

  // Look up a fetch PC with no ID instruction and check the prediction
  task automatic check_pred(input string tag, input logic [63:0] pc, input logic exp_t, input logic [63:0] exp_pc);
    @(negedge clk); idle(); ifupc = pc; #1;
    total++;
    if (pred_taken !== exp_t) begin $display("FAIL %s pred_taken got=%0b exp=%0b", tag, pred_taken, exp_t); bad++; end
    if (exp_t) begin
      total++;
      if (pred_pc !== exp_pc) begin $display("FAIL %s pred_pc got=%h exp=%h", tag, pred_pc, exp_pc); bad++; end
    end
  endtask

  task automatic test_reset();
    idle(); rst = 1; ifupc = 64'h8000_0000; #2;
    total++;
    if (pred_taken !== 1'b0) begin $display("FAIL rst_pred got=%0b exp=0", pred_taken); bad++; end
    total++;
    if (next_pc !== 64'h8000_0004) begin $display("FAIL rst_next got=%h exp=%h", next_pc, 64'h8000_0004); bad++; end
    total++;
    if (ifid_nop !== 1'b0) begin $display("FAIL rst_nop got=%0b exp=0", ifid_nop); bad++; end
    check_perf("rst");
    @(negedge clk); rst = 0;
    check_pred("rst_after", 64'h8000_0000, 1'b0, 64'h0);
  endtask

  task automatic test_alloc();
    @(negedge clk);
    drive_br(3'b000, 64'h8000_0010, 64'd5, 64'd5, 64'h20, 1'b0, 64'h0);
    ifupc = 64'h8000_0010; #1;
    total++;
    if (ifid_nop !== 1'b1) begin $display("FAIL alloc_nop got=%0b exp=1", ifid_nop); bad++; end
    total++;
    if (next_pc !== 64'h8000_0030) begin $display("FAIL alloc_next got=%h exp=%h", next_pc, 64'h8000_0030); bad++; end
    total++;
    if (pred_taken !== 1'b0) begin $display("FAIL alloc_same_cycle got=%0b exp=0", pred_taken); bad++; end
    exp_br++; exp_mis++;
    check_pred("alloc_hit", 64'h8000_0010, 1'b1, 64'h8000_0030);
    total++;
    if (next_pc !== 64'h8000_0030) begin $display("FAIL alloc_hit_next got=%h exp=%h", next_pc, 64'h8000_0030); bad++; end
    check_perf("alloc");
  endtask

  task automatic test_saturation();
    logic exp_nop [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic pt      [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic [63:0] a [4] = '{64'd1, 64'd1, 64'd1, 64'd1};
    logic [63:0] b [4] = '{64'd2, 64'd2, 64'd2, 64'd1};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive_br(3'b000, 64'h8000_0010, a[k], b[k], 64'h20, pt[k], 64'h8000_0030);
      ifupc = 64'h9000_0100; #1;
      total++;
      if (ifid_nop !== exp_nop[k]) begin $display("FAIL sat_nop%0d got=%0b exp=%0b", k, ifid_nop, exp_nop[k]); bad++; end
      exp_br++; if (exp_nop[k]) exp_mis++;
      check_pred($sformatf("sat_pred%0d", k), 64'h8000_0010, 1'b0, 64'h0);
    end
    check_perf("sat");
  endtask

  task automatic test_jalr();
    @(negedge clk); idle();
    id_valid = 1; jalr = 1; idupc = 64'h8000_0200; rs1 = 64'h8000_1001; imm = 64'd4;
    id_pred_taken = 1; id_pred_pc = 64'h8000_1004; ifupc = 64'h9000_0000; #1;
    total++;
    if (ifid_nop !== 1'b0) begin $display("FAIL jalr_ok_nop got=%0b exp=0", ifid_nop); bad++; end
    total++;
    if (next_pc !== 64'h9000_0004) begin $display("FAIL jalr_ok_next got=%h exp=%h", next_pc, 64'h9000_0004); bad++; end
    exp_br++;
    @(negedge clk);
    id_pred_pc = 64'h8000_1000; #1;
    total++;
    if (ifid_nop !== 1'b1) begin $display("FAIL jalr_bad_nop got=%0b exp=1", ifid_nop); bad++; end
    total++;
    if (next_pc !== 64'h8000_1004) begin $display("FAIL jalr_bad_next got=%h exp=%h", next_pc, 64'h8000_1004); bad++; end
    exp_br++; exp_mis++;
    check_pred("jalr_hit", 64'h8000_0200, 1'b1, 64'h8000_1004);
    check_pred("jalr_tagmiss", 64'h9000_0000, 1'b0, 64'h0);
    check_perf("jalr");
  endtask

  task automatic test_stall_clear();
    @(negedge clk);
    drive_br(3'b001, 64'h8000_0044, 64'd1, 64'd2, 64'h40, 1'b0, 64'h0);
    id_stall = 1; ifupc = 64'h9000_0100; #1;
    total++;
    if (ifid_nop !== 1'b1) begin $display("FAIL stall_nop got=%0b exp=1", ifid_nop); bad++; end
    total++;
    if (next_pc !== 64'h8000_0084) begin $display("FAIL stall_next got=%h exp=%h", next_pc, 64'h8000_0084); bad++; end
    check_pred("stall_noalloc", 64'h8000_0044, 1'b0, 64'h0);
    check_perf("stall");
    @(negedge clk);
    drive_br(3'b001, 64'h8000_0044, 64'd1, 64'd2, 64'h40, 1'b0, 64'h0);
    bht_clr = 1; #1;
    exp_br++; exp_mis++;
    check_pred("clr_alloc", 64'h8000_0044, 1'b0, 64'h0);
    check_pred("clr_jalr", 64'h8000_0200, 1'b0, 64'h0);
    check_perf("clr");
  endtask

  task automatic test_signed_unsigned();
    @(negedge clk); idle(); rst = 1; #1; rst = 0;
    exp_br = 0; exp_mis = 0;
    check_perf("cmp_rst");
    @(negedge clk);
    drive_br(3'b110, 64'h8000_0400, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h10, 1'b0, 64'h0);
    ifupc = 64'h9000_0100; #1;
    total++;
    if (ifid_nop !== 1'b0) begin $display("FAIL bltu_nop got=%0b exp=0", ifid_nop); bad++; end
    total++;
    if (next_pc !== 64'h9000_0104) begin $display("FAIL bltu_next got=%h exp=%h", next_pc, 64'h9000_0104); bad++; end
    exp_br++;
    @(negedge clk);
    bfun3 = 3'b100; #1;
    total++;
    if (ifid_nop !== 1'b1) begin $display("FAIL blt_nop got=%0b exp=1", ifid_nop); bad++; end
    total++;
    if (next_pc !== 64'h8000_0410) begin $display("FAIL blt_next got=%h exp=%h", next_pc, 64'h8000_0410); bad++; end
    exp_br++; exp_mis++;
    check_pred("blt_alloc", 64'h8000_0400, 1'b1, 64'h8000_0410);
    check_perf("cmp");
  endtask

  task automatic test_alias();
    @(negedge clk); idle();
    id_valid = 1; idupc = 64'h8000_0400; id_pred_taken = 1; id_pred_pc = 64'h8000_0410;
    ifupc = 64'h9000_0100; #1;
    total++;
    if (ifid_nop !== 1'b1) begin $display("FAIL alias_nop got=%0b exp=1", ifid_nop); bad++; end
    total++;
    if (next_pc !== 64'h8000_0404) begin $display("FAIL alias_next got=%h exp=%h", next_pc, 64'h8000_0404); bad++; end
    check_pred("alias_inv", 64'h8000_0400, 1'b0, 64'h0);
    check_perf("alias");
  endtask

  initial begin
    test_reset();
    test_alloc();
    test_saturation();
    test_jalr();
    test_stall_clear();
    test_signed_unsigned();
    test_alias();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bru_bht.md
Name: bru_bht

Overview:
Branch resolution unit with a direct-mapped branch history / target table (BHT+BTB) of 2-bit saturating counters.
- IF side: predicts next PC from the fetch PC.
- ID side: resolves branch/jal/jalr, detects misprediction, drives the redirect and IF/ID flush, and trains the table.
- Sits between pipe_pc_if and the ID stage.
- Successor to the static not-taken resolver: same resolve semantics, plus prediction, table state and optional perf counters.

Parameters:
- CPU_WIDTH, 64, data/PC width.
- BHT_DEPTH, 64, table entries; power of 2, ≥2.
- TAG_W, 8, tag bits stored per entry, taken from PC[IDX_W+2 +: TAG_W], where IDX_W = log2(BHT_DEPTH).
- CNT_INIT, 2'b10, counter value written on allocation.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous reset, active-high
- i_ifupc  in  CPU_WIDTH  fetch PC
- o_pred_taken  out  1  IF prediction for i_ifupc
- o_pred_pc  out  CPU_WIDTH  predicted target, valid when o_pred_taken=1
- i_id_valid  in  1  ID holds a valid instruction
- i_id_stall  in  1  ID stalled; blocks table and counter update
- i_jal, i_jalr, i_brch  in  1  ID instruction class, one-hot or none
- i_bfun3  in  3  branch funct3
- i_rs1, i_rs2, i_imm  in  CPU_WIDTH  operands
- i_idupc  in  CPU_WIDTH  ID-stage PC
- i_id_pred_taken  in  1  prediction carried with the ID instruction
- i_id_pred_pc  in  CPU_WIDTH  predicted target carried with the ID instruction
- i_bht_clr  in  1  synchronous clear of all valid bits
- o_next_pc  out  CPU_WIDTH  PC for pipe_pc_if
- o_ifid_nop  out  1  misprediction; flush IF/ID
- o_br_cnt  out  32  resolved control-transfer count
- o_mis_cnt  out  32  misprediction count

Behaviour:
- **Entry format:** valid, tag[TAG_W], target[CPU_WIDTH], cnt[2], is_jump.
- **Reset (async, i_rst=1):** every valid=0, cnt=2'b01, is_jump=0. Counters are 0.
  - Outputs during reset are combinational: o_pred_taken=0, o_ifid_nop=0 unless ID reports a mispredict, o_next_pc=i_ifupc+4.
- **Predict (combinational, 0 latency):**
  - idx=i_ifupc[IDX_W+1:2].
  - hit = valid[idx] & tag match.
  - o_pred_taken = hit & (is_jump | cnt[1]).
  - o_pred_pc = target[idx].
- **Resolve (combinational):**
  - Outcome taken: BEQ/BNE/BLT/BGE/BLTU/BGEU evaluated on rs1−rs2. Unsigned compare uses the CPU_WIDTH+1 borrow bit. Undefined funct3 = not taken.
  - taken = (i_brch & cond) | i_jal | i_jalr.
  - tgt = i_jalr ? (rs1+imm)&~1 : idupc+imm.
  - mis = i_id_valid & (taken≠i_id_pred_taken | (taken & tgt≠i_id_pred_pc)).
  - A non-control instruction with i_id_pred_taken=1 (alias) counts as a mispredict with taken=0.
- **o_next_pc priority:**
  1. mis → (taken ? tgt : idupc+4)
  2. o_pred_taken → o_pred_pc
  3. otherwise i_ifupc+4
- **o_ifid_nop** = mis. It is asserted regardless of i_id_stall; the pipeline controller owns stall/flush priority.
- **Update:** enable upd = i_id_valid & ~i_id_stall & (i_brch|i_jal|i_jalr), registered at the next i_clk edge. uidx/utag come from i_idupc.
  - On hit:
    - cnt saturating: +1 if taken, −1 if not taken; held at 3 and 0.
    - If taken, target←tgt.
    - is_jump←i_jal|i_jalr.
  - On miss and taken: allocate. valid=1, tag, target=tgt, cnt=CNT_INIT, is_jump. Replaces any occupant.
  - On miss and not taken: no allocation.
  - Alias mispredict on a non-control instruction: the hit entry at idx(i_idupc) is invalidated.
- **Same-index read/write in one cycle:** IF sees the old contents; the new contents are visible next cycle.
- **i_bht_clr:** all valid←0 at the edge. It has priority over a same-cycle update. Counters are unaffected.
- **Reset mid-update:** the table clears immediately and the pending write is lost.
- Sequential logic uses only posedge i_clk / posedge i_rst.

Optional Feature:
- **BRU_PERF_EN defined:**
  - o_br_cnt increments on every upd.
  - o_mis_cnt increments on upd & mis.
  - Both are 32-bit, wrap at 2^32, and reset to 0.
- **BRU_PERF_EN undefined:** both outputs are constant 0 and no counter flops exist.

Test Plan:
- **Reset, no table state:** reset, then i_ifupc=0x8000_0000 with no ID instruction → o_pred_taken=0, o_next_pc=0x8000_0004, o_ifid_nop=0.
- **Cold-miss BEQ, then allocation hit:**
  - Cycle 1: BEQ at idupc=0x8000_0010, rs1=rs2=5, imm=0x20, pred=0 → o_ifid_nop=1, o_next_pc=0x8000_0030.
  - Next cycle: i_ifupc=0x8000_0010 → o_pred_taken=1, o_pred_pc=0x8000_0030.
- **Counter saturation (same branch):**
  - 3 not-taken resolves (rs1=1, rs2=2): cnt goes 10→01→00→00. The first resolve mispredicts (o_ifid_nop=1); the later two do not.
  - Then 1 taken resolve → mispredict, cnt=01, prediction still not taken.
- **JALR:** rs1=0x8000_1001, imm=4 → tgt=0x8000_1004. With a prior matching prediction → o_ifid_nop=0; with i_id_pred_pc=0x8000_1000 → o_ifid_nop=1.
- **Stall and clear:**
  - Mispredicting BNE with i_id_stall=1 → o_ifid_nop=1, table and o_br_cnt unchanged.
  - i_bht_clr asserted together with an allocating update → entry stays invalid.
- **BLTU vs BLT:** rs1=0xFFFF_FFFF_FFFF_FFFF, rs2=1. BLTU not taken, BLT taken. With BRU_PERF_EN: o_br_cnt=2; o_mis_cnt matches the injected i_id_pred_taken values.
